// File: rtl/clk_diag_sequencer.sv
// Front-end CLK diagnostic sequencer: issues EBUS diag functions (FIFO-fed or
// the built-in KL master-reset macro) with strobe timing locked to MHZ16_FREE.
`timescale 1ns/1ps
module clk_diag_sequencer #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned HOLD_EDGES    = 8,
  parameter int unsigned RECOVER_EDGES = 4
) (
  input  logic       clk,
  input  logic       CROBAR_N,
  input  logic       mhz16Free,
  input  logic       fnValid,
  input  logic [6:0] fnCode,
  output logic       fnReady,
  input  logic       mrStart,
  output logic [6:0] ds,
  output logic       diagStrobe,
  output logic       busy,
  output logic       fnDone,
  output logic       mrDone,
  output logic       mrReject
);

  localparam int unsigned CODE_W = 7;
  localparam int unsigned AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = AW + 1;
  localparam int unsigned CW     = $clog2(HOLD_EDGES + RECOVER_EDGES + 1);
  localparam int unsigned PW     = 4;
  localparam logic [PW-1:0] MR_LAST = 4'd10;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_HOLD    = 3'd2;
  localparam logic [2:0] S_RECOVER = 3'd3;
  localparam logic [2:0] S_NEXT    = 3'd4;

  // KL master-reset macro
  function automatic logic [CODE_W-1:0] mr_rom(input logic [PW-1:0] idx);
    case (idx)
      4'd0:    mr_rom = 7'o044;
      4'd1:    mr_rom = 7'o000;
      4'd2:    mr_rom = 7'o007;
      4'd3:    mr_rom = 7'o046;
      4'd4:    mr_rom = 7'o047;
      4'd5:    mr_rom = 7'o047;
      4'd6:    mr_rom = 7'o047;
      4'd7:    mr_rom = 7'o042;
      4'd8:    mr_rom = 7'o043;
      4'd9:    mr_rom = 7'o052;
      4'd10:   mr_rom = 7'o051;
      default: mr_rom = 7'o000;
    endcase
  endfunction

  logic              s1, s2;
  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic              macro_q, macro_d;
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CODE_W-1:0] mem [FIFO_DEPTH];
  logic [CODE_W-1:0] ds_q, ds_d;
  logic              strobe_q, strobe_d;
  logic              fnready_q, fnready_d;
  logic              busy_q, busy_d;
  logic              fndone_q, fndone_d;
  logic              mrdone_q, mrdone_d;
  logic              mrreject_q, mrreject_d;
  logic              push, pop, accept_mr, fe, re;

  assign fe = s2 & ~s1;
  assign re = ~s2 & s1;

  assign fnReady    = fnready_q;
  assign ds         = ds_q;
  assign diagStrobe = strobe_q;
  assign busy       = busy_q;
  assign fnDone     = fndone_q;
  assign mrDone     = mrdone_q;
  assign mrReject   = mrreject_q;

  // Next-state, FIFO bookkeeping and output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    code_d     = code_q;
    ptr_d      = ptr_q;
    macro_d    = macro_q;
    ds_d       = ds_q;
    strobe_d   = strobe_q;
    fndone_d   = 1'b0;
    mrdone_d   = 1'b0;
    mrreject_d = 1'b0;
    pop        = 1'b0;
    push       = fnValid & fnready_q;
    accept_mr  = (state_q == S_IDLE) && (count_q == '0);
    if (mrStart && !accept_mr) mrreject_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (mrStart && accept_mr) begin
          macro_d = 1'b1;
          ptr_d   = '0;
          code_d  = mr_rom('0);
          state_d = S_SETUP;
        end else if (count_q != '0) begin
          pop     = 1'b1;
          code_d  = mem[rptr_q];
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (fe) begin
          ds_d     = code_q;
          strobe_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (fe) begin
          if (cnt_q == CW'(HOLD_EDGES)) begin
            ds_d     = '0;
            strobe_d = 1'b0;
            cnt_d    = '0;
            state_d  = S_RECOVER;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_RECOVER: begin
        if (re) begin
          if (cnt_q == CW'(RECOVER_EDGES - 1)) begin
            fndone_d = 1'b1;
            cnt_d    = '0;
            state_d  = S_NEXT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_NEXT: begin
        if (macro_q && (ptr_q < MR_LAST)) begin
          ptr_d   = ptr_q + PW'(1);
          code_d  = mr_rom(ptr_q + PW'(1));
          state_d = S_SETUP;
        end else begin
          mrdone_d = macro_q;
          macro_d  = 1'b0;
          ptr_d    = '0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    fnready_d = (count_d != CNT_W'(FIFO_DEPTH)) && !macro_d;
    busy_d    = (state_d != S_IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk or negedge CROBAR_N) begin
    if (!CROBAR_N) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      code_q     <= '0;
      ptr_q      <= '0;
      macro_q    <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      ds_q       <= '0;
      strobe_q   <= 1'b0;
      fnready_q  <= 1'b1;
      busy_q     <= 1'b0;
      fndone_q   <= 1'b0;
      mrdone_q   <= 1'b0;
      mrreject_q <= 1'b0;
    end else begin
      s1         <= mhz16Free;
      s2         <= s1;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      ptr_q      <= ptr_d;
      macro_q    <= macro_d;
      wptr_q     <= push ? wptr_q + AW'(1) : wptr_q;
      rptr_q     <= pop ? rptr_q + AW'(1) : rptr_q;
      count_q    <= count_d;
      ds_q       <= ds_d;
      strobe_q   <= strobe_d;
      fnready_q  <= fnready_d;
      busy_q     <= busy_d;
      fndone_q   <= fndone_d;
      mrdone_q   <= mrdone_d;
      mrreject_q <= mrreject_d;
    end
  end

  // Queue storage needs no reset; occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= fnCode;
  end

endmodule

// File: tb/tb_clk_diag_sequencer.sv
// Directed bench for clk_diag_sequencer: table of single functions plus
// hand-written FIFO, macro, reject and reset sequences.
`timescale 1ns/1ps
module tb_clk_diag_sequencer;

  logic       clk = 1'b0;
  logic       CROBAR_N = 1'b1;
  logic       mhz16Free = 1'b0;
  logic       fnValid = 1'b0;
  logic [6:0] fnCode = 7'o000;
  logic       mrStart = 1'b0;
  logic       fnReady, diagStrobe, busy, fnDone, mrDone, mrReject;
  logic [6:0] ds;
  bit         m16_run = 1'b1;

  int total = 0;
  int passed = 0;

  typedef struct {
    logic [6:0] code;
    logic [6:0] exp_ds;
    realtime    exp_w;
    realtime    exp_r;
  } vec_t;

  vec_t       vecs [4];
  logic [6:0] mr_exp [11];

  clk_diag_sequencer dut (
    .clk(clk), .CROBAR_N(CROBAR_N), .mhz16Free(mhz16Free), .fnValid(fnValid),
    .fnCode(fnCode), .fnReady(fnReady), .mrStart(mrStart), .ds(ds),
    .diagStrobe(diagStrobe), .busy(busy), .fnDone(fnDone), .mrDone(mrDone),
    .mrReject(mrReject)
  );

  initial forever #10 clk = ~clk;

  initial forever begin
    if (m16_run) #31.25 mhz16Free = ~mhz16Free;
    else #1;
  end

  // Strobe/done monitor
  realtime    last_fe = 0.0;
  realtime    rise_t = 0.0;
  realtime    fall_t = 0.0;
  logic [6:0] rise_ds = 7'o000;
  bit         stab = 1'b1;
  bit         prev_strobe = 1'b0;
  logic [6:0] sds_q [$];
  realtime    wid_q [$];
  realtime    rec_q [$];
  realtime    lat_q [$];
  bit         stab_q [$];
  int rise_cnt = 0, done_cnt = 0, mrdone_cnt = 0, rej_cnt = 0, ds_bad = 0;

  initial forever begin
    @(negedge mhz16Free);
    last_fe = $realtime;
  end

  initial forever begin
    @(negedge clk);
    if (diagStrobe && !prev_strobe) begin
      rise_t = $realtime; rise_ds = ds; stab = 1'b1; rise_cnt++;
      lat_q.push_back(rise_t - last_fe);
    end
    if (diagStrobe && prev_strobe && ds !== rise_ds) stab = 1'b0;
    if (!diagStrobe && prev_strobe) begin
      fall_t = $realtime;
      sds_q.push_back(rise_ds); wid_q.push_back(fall_t - rise_t); stab_q.push_back(stab);
    end
    if (!diagStrobe && CROBAR_N && ds !== 7'o000) ds_bad++;
    if (fnDone) begin done_cnt++; rec_q.push_back($realtime - fall_t); end
    if (mrDone) mrdone_cnt++;
    if (mrReject) rej_cnt++;
    prev_strobe = diagStrobe;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic chk_rng(input string name, input realtime v, input realtime lo, input realtime hi);
    total++;
    if (v >= lo && v <= hi) passed++;
    else $display("FAIL %s: got %0.2f ns, expected %0.2f..%0.2f ns", name, v, lo, hi);
  endtask

  task automatic push(input logic [6:0] c, output bit acc);
    fnValid = 1'b1;
    fnCode  = c;
    acc     = fnReady;
    tick();
    fnValid = 1'b0;
  endtask

  task automatic pulse_mr();
    mrStart = 1'b1;
    tick();
    mrStart = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rise(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (rise_cnt >= n) begin ok = 1'b1; break; end
    end
  endtask

  initial begin
    bit acc, ok;
    int bd, bq, br, bm, bad, dn;

    vecs[0] = '{code: 7'o001, exp_ds: 7'o001, exp_w: 562.5, exp_r: 218.75};
    vecs[1] = '{code: 7'o177, exp_ds: 7'o177, exp_w: 562.5, exp_r: 218.75};
    vecs[2] = '{code: 7'o052, exp_ds: 7'o052, exp_w: 562.5, exp_r: 218.75};
    vecs[3] = '{code: 7'o100, exp_ds: 7'o100, exp_w: 562.5, exp_r: 218.75};
    mr_exp = '{7'o044, 7'o000, 7'o007, 7'o046, 7'o047, 7'o047, 7'o047, 7'o042, 7'o043, 7'o052, 7'o051};

    #5 CROBAR_N = 1'b0;
    repeat (3) tick();
    chk("rst ds", 32'(ds), 0);
    chk("rst diagStrobe", 32'(diagStrobe), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst fnDone", 32'(fnDone), 0);
    chk("rst mrDone", 32'(mrDone), 0);
    chk("rst mrReject", 32'(mrReject), 0);
    chk("rst fnReady", 32'(fnReady), 1);
    CROBAR_N = 1'b1;
    repeat (2) tick();

    // Table of single functions
    for (int v = 0; v < 4; v++) begin
      bd = done_cnt; bq = sds_q.size();
      push(vecs[v].code, acc);
      chk($sformatf("v%0d accepted", v), 32'(acc), 1);
      wait_done(bd + 1, 300, ok);
      chk($sformatf("v%0d done timeout", v), 32'(ok), 1);
      chk($sformatf("v%0d busy at fnDone", v), 32'(busy), 1);
      tick();
      chk($sformatf("v%0d busy after fnDone", v), 32'(busy), 0);
      chk($sformatf("v%0d strobes", v), 32'(sds_q.size() - bq), 1);
      if (sds_q.size() > bq) begin
        chk($sformatf("v%0d ds", v), 32'(sds_q[bq]), 32'(vecs[v].exp_ds));
        chk_rng($sformatf("v%0d width", v), wid_q[bq], vecs[v].exp_w - 25.0, vecs[v].exp_w + 25.0);
        chk_rng($sformatf("v%0d launch", v), lat_q[bq], 10.0, 55.0);
        chk($sformatf("v%0d ds stable", v), 32'(stab_q[bq]), 1);
      end
      chk_rng($sformatf("v%0d recover", v), rec_q[rec_q.size() - 1], vecs[v].exp_r - 25.0, vecs[v].exp_r + 25.0);
      repeat (5) tick();
    end

    // Three back-to-back pushes
    bd = done_cnt; bq = sds_q.size(); br = rec_q.size(); bad = 0;
    push(7'o007, acc); chk("b2b push0", 32'(acc), 1);
    push(7'o006, acc); chk("b2b push1", 32'(acc), 1);
    push(7'o067, acc); chk("b2b push2", 32'(acc), 1);
    ok = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (!fnReady) bad++;
      tick();
      if (done_cnt >= bd + 3) begin ok = 1'b1; break; end
    end
    chk("b2b done timeout", 32'(ok), 1);
    chk("b2b fnReady low cycles", 32'(bad), 0);
    if (sds_q.size() >= bq + 3 && rec_q.size() >= br + 3) begin
      chk("b2b ds0", 32'(sds_q[bq]), 32'(7'o007));
      chk("b2b ds1", 32'(sds_q[bq + 1]), 32'(7'o006));
      chk("b2b ds2", 32'(sds_q[bq + 2]), 32'(7'o067));
      for (int k = 0; k < 3; k++) begin
        chk_rng($sformatf("b2b width%0d", k), wid_q[bq + k], 537.5, 587.5);
        chk_rng($sformatf("b2b recover%0d", k), rec_q[br + k], 193.75, 243.75);
      end
    end else begin
      chk("b2b strobe count", 32'(sds_q.size() - bq), 3);
    end
    repeat (5) tick();

    // FIFO fills while the clock is stopped mid-strobe
    bd = done_cnt; bq = sds_q.size(); br = rise_cnt;
    push(7'o011, acc); chk("full push0", 32'(acc), 1);
    wait_rise(br + 1, 300, ok); chk("full rise timeout", 32'(ok), 1);
    m16_run = 1'b0;
    repeat (5) tick();
    push(7'o021, acc); chk("full push1", 32'(acc), 1);
    push(7'o022, acc); chk("full push2", 32'(acc), 1);
    push(7'o023, acc); chk("full push3", 32'(acc), 1);
    chk("full fnReady before 4th", 32'(fnReady), 1);
    push(7'o024, acc); chk("full push4", 32'(acc), 1);
    chk("full fnReady after 4th", 32'(fnReady), 0);
    push(7'o025, acc); chk("full push5 refused", 32'(acc), 0);
    repeat (20) tick();
    chk("stopped strobe holds", 32'(diagStrobe), 1);
    chk("stopped ds holds", 32'(ds), 32'(7'o011));
    m16_run = 1'b1;
    wait_done(bd + 5, 1500, ok); chk("full drain timeout", 32'(ok), 1);
    repeat (150) tick();
    chk("full total fnDone", 32'(done_cnt - bd), 5);
    chk("full busy idle", 32'(busy), 0);
    if (sds_q.size() >= bq + 5) begin
      chk("full ds0", 32'(sds_q[bq]), 32'(7'o011));
      chk("full ds1", 32'(sds_q[bq + 1]), 32'(7'o021));
      chk("full ds4", 32'(sds_q[bq + 4]), 32'(7'o024));
    end

    // Master-reset macro from idle
    bd = done_cnt; bq = sds_q.size(); bm = mrdone_cnt; br = rej_cnt; bad = 0; dn = 0;
    pulse_mr();
    chk("mr no reject", 32'(mrReject), 0);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (mrdone_cnt > bm) begin ok = 1'b1; dn = done_cnt - bd; break; end
      if (fnReady) bad++;
    end
    chk("mr done timeout", 32'(ok), 1);
    chk("mr fnDone before mrDone", 32'(dn), 11);
    chk("mr fnReady high cycles", 32'(bad), 0);
    chk("mr strobe count", 32'(sds_q.size() - bq), 11);
    if (sds_q.size() >= bq + 11) begin
      bad = 0;
      for (int k = 0; k < 11; k++) begin
        chk($sformatf("mr ds%0d", k), 32'(sds_q[bq + k]), 32'(mr_exp[k]));
        if (wid_q[bq + k] < 537.5 || wid_q[bq + k] > 587.5) bad++;
      end
      chk("mr widths out of range", 32'(bad), 0);
    end
    repeat (100) tick();
    chk("mr single mrDone", 32'(mrdone_cnt - bm), 1);
    chk("mr rejects", 32'(rej_cnt - br), 0);
    chk("mr fnReady after", 32'(fnReady), 1);

    // mrStart refused while a function holds
    bd = done_cnt; bq = sds_q.size(); bm = mrdone_cnt; br = rise_cnt;
    push(7'o055, acc); chk("rej push", 32'(acc), 1);
    wait_rise(br + 1, 300, ok); chk("rej rise timeout", 32'(ok), 1);
    repeat (3) tick();
    pulse_mr();
    chk("rej mrReject pulse", 32'(mrReject), 1);
    chk("rej fnReady", 32'(fnReady), 1);
    tick();
    chk("rej mrReject single", 32'(mrReject), 0);
    wait_done(bd + 1, 300, ok); chk("rej done timeout", 32'(ok), 1);
    repeat (200) tick();
    chk("rej strobes", 32'(rise_cnt - br), 1);
    if (sds_q.size() > bq) chk("rej ds", 32'(sds_q[bq]), 32'(7'o055));
    chk("rej no mrDone", 32'(mrdone_cnt - bm), 0);
    chk("rej busy idle", 32'(busy), 0);

    // Reset during a macro entry's HOLD
    bm = mrdone_cnt; br = rise_cnt;
    pulse_mr();
    wait_rise(br + 3, 600, ok); chk("rst mr rise timeout", 32'(ok), 1);
    repeat (3) tick();
    #2 CROBAR_N = 1'b0;
    #1;
    chk("rst async diagStrobe", 32'(diagStrobe), 0);
    chk("rst async ds", 32'(ds), 0);
    repeat (3) tick();
    CROBAR_N = 1'b1;
    tick();
    chk("post rst busy", 32'(busy), 0);
    chk("post rst fnReady", 32'(fnReady), 1);
    repeat (300) tick();
    chk("post rst no strobes", 32'(rise_cnt - br), 3);
    chk("post rst no mrDone", 32'(mrdone_cnt - bm), 0);
    chk("post rst busy late", 32'(busy), 0);

    bad = 0;
    foreach (stab_q[k]) if (!stab_q[k]) bad++;
    chk("ds unstable strobes", 32'(bad), 0);
    chk("ds nonzero while strobe low", 32'(ds_bad), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
